// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one CBus master port between N requesters, grant held for a full burst.
// Optional protocol checker (beat counter + sticky proto_err) is enabled by defining CBUS_ARB_CHECK_EN.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_rr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
`ifdef CBUS_ARB_CHECK_EN
  ,
  output logic             proto_err
`endif
);

  localparam int CW = IDX_W + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] sel_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [CW-1:0]    cand;
  logic             any_valid;
  logic             release_txn;

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-two counts work.
  always_comb begin
    any_valid = 1'b0;
    sel_d     = rr_ptr_q;
    cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NUM_INPUTS)) begin
        cand = cand - CW'(NUM_INPUTS);
      end
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (!any_valid && (cand == CW'(j)) && ireqs[j].valid) begin
          any_valid = 1'b1;
          sel_d     = IDX_W'(j);
        end
      end
    end
  end

  assign rr_ptr_d    = (sel_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_q + 1'b1;
  assign release_txn = (state_q == BUSY) && oresp.ready && oresp.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            sel_q   <= sel_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (release_txn) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The granted requester is wired straight through; everyone else sees an all-zero response.
  always_comb begin
    oreq = '0;
    for (int j = 0; j < NUM_INPUTS; j++) begin
      iresps[j] = '0;
      if ((state_q == BUSY) && (sel_q == IDX_W'(j))) begin
        oreq      = ireqs[j];
        iresps[j] = oresp;
      end
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_idx = sel_q;

`ifdef CBUS_ARB_CHECK_EN
  logic [8:0] beat_cnt_q;
  logic       proto_err_q;
  logic       err_len;
  logic       err_over;
  logic       err_valid;

  // beat_cnt_q counts beats already accepted, so the last beat must arrive with count == len.
  assign err_len   = busy && oresp.ready && oresp.last && (beat_cnt_q != {1'b0, oreq.len});
  assign err_over  = busy && oresp.ready && !oresp.last && (beat_cnt_q >= {1'b0, oreq.len});
  assign err_valid = busy && !oreq.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && any_valid) begin
        beat_cnt_q <= '0;
      end else if (busy && oresp.ready && (beat_cnt_q != '1)) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (err_len || err_over || err_valid) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err = proto_err_q;

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset && err_len)   $error("cbus_rr_arbiter: last with wrong beat count, sel=%0d", sel_q);
    if (!reset && err_over)  $error("cbus_rr_arbiter: beat count exceeds len, sel=%0d", sel_q);
    if (!reset && err_valid) $error("cbus_rr_arbiter: valid dropped during burst, sel=%0d", sel_q);
  end
`endif
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed self-checking bench for cbus_rr_arbiter: a 2-input and a 3-input instance share one clock and reset.
// Protocol-error checks are compiled in only when CBUS_ARB_CHECK_EN is defined.

module tb_cbus_rr_arbiter;
  import cbus_pkg::*;

  localparam logic [31:0] ADDR0 = 32'h1FC0_0000;
  localparam logic [31:0] ADDR1 = 32'h8000_1000;
  localparam logic [31:0] ADDR2 = 32'h8000_2000;

  logic       clk;
  logic       reset;
  cbus_req_t  ireqs   [2];
  cbus_resp_t iresps  [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       grant_idx;
  logic       busy;

  cbus_req_t  ireqs3  [3];
  cbus_resp_t iresps3 [3];
  cbus_req_t  oreq3;
  cbus_resp_t oresp3;
  logic [1:0] grant3;
  logic       busy3;

`ifdef CBUS_ARB_CHECK_EN
  logic proto_err;
  logic proto_err3;
`endif

  int vectors;
  int miscompares;

  cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef CBUS_ARB_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs3),
    .iresps    (iresps3),
    .oreq      (oreq3),
    .oresp     (oresp3),
    .grant_idx (grant3),
    .busy      (busy3)
`ifdef CBUS_ARB_CHECK_EN
    ,
    .proto_err (proto_err3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len);
    cbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.size  = 2'd2;
    r.addr  = addr;
    r.len   = len;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int j = 0; j < 2; j++) ireqs[j] = '0;
    for (int j = 0; j < 3; j++) ireqs3[j] = '0;
    oresp  = '0;
    oresp3 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    oresp = mk_resp(1'b1, 1'b1, 32'h1234_5678);
    step();
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    vectors++;
    if (grant_idx !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_grant: got %0d want 0", grant_idx); end
    vectors++;
    if (oreq !== '0) begin miscompares++; $display("[TB] FAIL reset_oreq: got %h want 0", oreq); end
    vectors++;
    if (iresps[0] !== '0 || iresps[1] !== '0) begin
      miscompares++; $display("[TB] FAIL reset_iresps: got %h/%h want 0/0", iresps[0], iresps[1]);
    end
    vectors++;
    if (busy3 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy3: got %0b want 0", busy3); end
    oresp = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    #1;
    vectors++;
    if (oreq.valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_latency: oreq.valid got %0b want 0", oreq.valid); end
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy: got %0b want 1", busy); end
    vectors++;
    if (grant_idx !== 1'b0) begin miscompares++; $display("[TB] FAIL single_grant: got %0d want 0", grant_idx); end
    vectors++;
    if (oreq.valid !== 1'b1 || oreq.addr !== ADDR0) begin
      miscompares++; $display("[TB] FAIL single_oreq: got valid=%0b addr=%h want 1/%h", oreq.valid, oreq.addr, ADDR0);
    end
    step();
    vectors++;
    if (iresps[0].ready !== 1'b0) begin miscompares++; $display("[TB] FAIL single_noready: got %0b want 0", iresps[0].ready); end
    step();
    oresp = mk_resp(1'b1, 1'b1, 32'hCAFE_F00D);
    #1;
    vectors++;
    if (iresps[0].ready !== 1'b1 || iresps[0].data !== 32'hCAFE_F00D) begin
      miscompares++; $display("[TB] FAIL single_resp: got ready=%0b data=%h want 1/cafef00d", iresps[0].ready, iresps[0].data);
    end
    vectors++;
    if (iresps[1] !== '0) begin miscompares++; $display("[TB] FAIL single_other: got %h want 0", iresps[1]); end
    step();
    oresp = '0;
    ireqs[0] = '0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_release: busy got %0b want 0", busy); end
  endtask

  // Continues from test_single: rr_ptr should now be 1, so requester 1 wins a tie.
  task automatic test_rr_ptr();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    ireqs[1] = mk_req(ADDR1, 8'd0);
    step();
    vectors++;
    if (busy !== 1'b1 || grant_idx !== 1'b1 || oreq.addr !== ADDR1) begin
      miscompares++; $display("[TB] FAIL rr_ptr_tie: got busy=%0b grant=%0d addr=%h want 1/1/%h", busy, grant_idx, oreq.addr, ADDR1);
    end
    oresp = mk_resp(1'b1, 1'b1, 32'h0);
    step();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic        exp;
    logic [31:0] exp_addr;
    do_reset();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    ireqs[1] = mk_req(ADDR1, 8'd0);
    step();
    for (int n = 0; n < 3; n++) begin
      exp      = (n % 2 == 1);
      exp_addr = exp ? ADDR1 : ADDR0;
      #1;
      vectors++;
      if (busy !== 1'b1 || grant_idx !== exp || oreq.addr !== exp_addr) begin
        miscompares++; $display("[TB] FAIL b2b_grant%0d: got busy=%0b grant=%0d addr=%h want 1/%0d/%h", n, busy, grant_idx, oreq.addr, exp, exp_addr);
      end
      oresp = mk_resp(1'b1, 1'b1, 32'h0000_0100 + 32'(n));
      #1;
      vectors++;
      if (iresps[exp].ready !== 1'b1 || iresps[!exp].ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL b2b_route%0d: got granted=%0b other=%0b want 1/0", n, iresps[exp].ready, iresps[!exp].ready);
      end
      step();
      oresp = '0;
      #1;
      vectors++;
      if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL b2b_bubble%0d: got busy=%0b oreq.valid=%0b want 0/0", n, busy, oreq.valid);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_burst();
    logic [4:0] rdy;
    logic [4:0] lst;
    rdy = 5'b11101;
    lst = 5'b10000;
    do_reset();
    ireqs[1] = mk_req(ADDR1, 8'd3);
    step();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    for (int b = 0; b < 5; b++) begin
      oresp = mk_resp(rdy[b], lst[b], 32'h0000_B000 + 32'(b));
      #1;
      vectors++;
      if (busy !== 1'b1 || grant_idx !== 1'b1 || iresps[0].ready !== 1'b0 || iresps[1].ready !== rdy[b]) begin
        miscompares++;
        $display("[TB] FAIL burst_beat%0d: got busy=%0b grant=%0d r0=%0b r1=%0b want 1/1/0/%0b", b, busy, grant_idx, iresps[0].ready, iresps[1].ready, rdy[b]);
      end
      step();
    end
    oresp = '0;
    ireqs[1] = '0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_bubble: busy got %0b want 0", busy); end
    step();
    vectors++;
    if (busy !== 1'b1 || grant_idx !== 1'b0 || oreq.addr !== ADDR0) begin
      miscompares++; $display("[TB] FAIL burst_next: got busy=%0b grant=%0d addr=%h want 1/0/%h", busy, grant_idx, oreq.addr, ADDR0);
    end
    oresp = mk_resp(1'b1, 1'b1, 32'h0);
    step();
    clear_inputs();
  endtask

  task automatic test_valid_drop();
    do_reset();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    step();
    ireqs[0].valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b1 || oreq.valid !== 1'b0 || oreq.addr !== ADDR0) begin
      miscompares++; $display("[TB] FAIL drop_forward: got busy=%0b valid=%0b addr=%h want 1/0/%h", busy, oreq.valid, oreq.addr, ADDR0);
    end
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_hold: busy got %0b want 1", busy); end
    oresp = mk_resp(1'b1, 1'b1, 32'h0);
    #1;
    vectors++;
    if (iresps[0].ready !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_resp: got %0b want 1", iresps[0].ready); end
    step();
    oresp = '0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_release: busy got %0b want 0", busy); end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    ireqs[0] = mk_req(ADDR0, 8'd0);
    step();
    oresp = mk_resp(1'b1, 1'b1, 32'h0);
    step();
    oresp = '0;
    ireqs[1] = mk_req(ADDR1, 8'd0);
    step();
    vectors++;
    if (grant_idx !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_pre: grant got %0d want 1", grant_idx); end
    step();
    reset = 1'b1;
    oresp = mk_resp(1'b1, 1'b0, 32'h5555_AAAA);
    step();
    vectors++;
    if (busy !== 1'b0 || oreq.valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrst_idle: got busy=%0b valid=%0b want 0/0", busy, oreq.valid);
    end
    vectors++;
    if (iresps[0] !== '0 || iresps[1] !== '0) begin
      miscompares++; $display("[TB] FAIL midrst_iresps: got %h/%h want 0/0", iresps[0], iresps[1]);
    end
    reset = 1'b0;
    oresp = '0;
    step();
    vectors++;
    if (busy !== 1'b1 || grant_idx !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midrst_restart: got busy=%0b grant=%0d want 1/0", busy, grant_idx);
    end
    clear_inputs();
  endtask

  task automatic test_three_inputs();
    logic [1:0]  exp;
    logic [31:0] exp_addr;
    do_reset();
    ireqs3[0] = mk_req(ADDR0, 8'd0);
    ireqs3[1] = mk_req(ADDR1, 8'd0);
    ireqs3[2] = mk_req(ADDR2, 8'd0);
    step();
    for (int n = 0; n < 6; n++) begin
      exp      = 2'(n % 3);
      exp_addr = (exp == 2'd0) ? ADDR0 : (exp == 2'd1) ? ADDR1 : ADDR2;
      #1;
      vectors++;
      if (busy3 !== 1'b1 || grant3 !== exp || oreq3.addr !== exp_addr) begin
        miscompares++; $display("[TB] FAIL three_grant%0d: got busy=%0b grant=%0d addr=%h want 1/%0d/%h", n, busy3, grant3, oreq3.addr, exp, exp_addr);
      end
      oresp3 = mk_resp(1'b1, 1'b1, 32'h0);
      #1;
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (iresps3[j].ready !== (2'(j) == exp)) begin
          miscompares++; $display("[TB] FAIL three_route%0d_%0d: got %0b want %0b", n, j, iresps3[j].ready, (2'(j) == exp));
        end
      end
      step();
      oresp3 = '0;
      #1;
      vectors++;
      if (busy3 !== 1'b0) begin miscompares++; $display("[TB] FAIL three_bubble%0d: busy got %0b want 0", n, busy3); end
      step();
    end
    clear_inputs();
  endtask

`ifdef CBUS_ARB_CHECK_EN
  task automatic test_proto_err();
    do_reset();
    #1;
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL perr_reset: got %0b want 0", proto_err); end
    ireqs[0] = mk_req(ADDR0, 8'd1);
    step();
    oresp = mk_resp(1'b1, 1'b1, 32'h0);
    #1;
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL perr_early: got %0b want 0", proto_err); end
    step();
    oresp = '0;
    ireqs[0] = '0;
    #1;
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL perr_set: got %0b want 1", proto_err); end
    step();
    step();
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("[TB] FAIL perr_sticky: got %0b want 1", proto_err); end
    do_reset();
    #1;
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL perr_clear: got %0b want 0", proto_err); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_rr_ptr();
    test_back_to_back();
    test_burst();
    test_valid_drop();
    test_mid_reset();
    test_three_inputs();
`ifdef CBUS_ARB_CHECK_EN
    test_proto_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
